// File: rtl/mont_redc_ws_if.sv
// Handshake and operand/result bundle for the word-serial Montgomery reducer.
// The master side supplies operands and consumes results.
interface mont_redc_ws_if #(
    parameter int P_WIDTH  = 64,
    parameter int W_WIDTH  = 32,
    parameter int PD_WIDTH = 2 * P_WIDTH
);
    logic                in_valid;
    logic                in_ready;
    logic [PD_WIDTH-1:0] Mul_in;
    logic [P_WIDTH-1:0]  N_in;
    logic [W_WIDTH-1:0]  Nprime_in;
    logic                out_valid;
    logic                out_ready;
    logic [P_WIDTH-1:0]  res_out;
    logic [P_WIDTH:0]    res_raw_out;

    modport master (
        output in_valid, Mul_in, N_in, Nprime_in, out_ready,
        input  in_ready, out_valid, res_out, res_raw_out
    );

    modport slave (
        input  in_valid, Mul_in, N_in, Nprime_in, out_ready,
        output in_ready, out_valid, res_out, res_raw_out
    );
endinterface

// File: rtl/mont_redc_ws.sv
// Word-serial Montgomery reduction: T * 2^-P mod N, one W-bit word per cycle,
// then a single conditional-subtract cycle.
module mont_redc_ws #(
    parameter int P_WIDTH  = 64,
    parameter int W_WIDTH  = 32,
    parameter int PD_WIDTH = 2 * P_WIDTH,
    parameter int NUM_W    = P_WIDTH / W_WIDTH
) (
    input logic           clk,
    input logic           rst_n,
    mont_redc_ws_if.slave bus
);
    localparam int CNT_W = $clog2(NUM_W + 1);
    localparam int ACC_W = PD_WIDTH + 1;
    localparam int MN_W  = W_WIDTH + P_WIDTH;

    typedef enum logic [1:0] {IDLE, RED, SUB, DONE} state_t;

    state_t             state, state_nxt;
    logic [ACC_W-1:0]   acc;
    logic [P_WIDTH-1:0] n_reg;
    logic [W_WIDTH-1:0] np_reg;
    logic [CNT_W-1:0]   cnt;
    logic               in_ready;
    logic               accept;
    logic               last_iter;
    logic               out_valid;
    logic [P_WIDTH-1:0] res_q;
    logic [P_WIDTH:0]   raw_q;

    logic [W_WIDTH-1:0] m;
    logic [MN_W-1:0]    m_n;
    logic [ACC_W-1:0]   sum;
    logic [P_WIDTH:0]   raw;
    logic [P_WIDTH-1:0] diff;
    logic               raw_ge_n;

    // m is only needed modulo 2^W, so the W-bit result width truncates for free.
    assign m         = acc[W_WIDTH-1:0] * np_reg;
    assign m_n       = MN_W'(m) * MN_W'(n_reg);
    assign sum       = acc + ACC_W'(m_n);
    assign raw       = acc[P_WIDTH:0];
    assign raw_ge_n  = raw >= {1'b0, n_reg};
    assign diff      = raw[P_WIDTH-1:0] - n_reg;
    assign last_iter = (cnt == CNT_W'(NUM_W - 1));
    assign accept    = bus.in_valid && in_ready;

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid;
    assign bus.res_out     = res_q;
    assign bus.res_raw_out = raw_q;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no branch can infer a latch.
        state_nxt = state;
        in_ready  = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) state_nxt = RED;
            end
            RED:  if (last_iter) state_nxt = SUB;
            SUB:  state_nxt = DONE;
            DONE: begin
                // Taking a result frees the engine in the same cycle.
                in_ready = bus.out_ready;
                if (bus.out_ready) state_nxt = bus.in_valid ? RED : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc       <= '0;
            n_reg     <= '0;
            np_reg    <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            res_q     <= '0;
            raw_q     <= '0;
        end else begin
            if (accept) begin
                acc    <= {1'b0, bus.Mul_in};
                n_reg  <= bus.N_in;
                np_reg <= bus.Nprime_in;
                cnt    <= '0;
            end else if (state == RED) begin
                // Low W bits of sum are zero by construction of m.
                acc <= sum >> W_WIDTH;
                cnt <= cnt + 1'b1;
            end

            if (state == SUB) begin
                res_q     <= raw_ge_n ? diff : raw[P_WIDTH-1:0];
                raw_q     <= raw;
                out_valid <= 1'b1;
            end else if (state == DONE && bus.out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mont_redc_ws.sv
// Randomized self-checking bench for mont_redc_ws at three P/W configurations,
// checked against a bit-serial modular-halving reference.
module tb_mont_redc_ws;
    localparam int NRND = 2000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic [1:0]   sel;
    logic         in_valid;
    logic         out_ready;
    logic [255:0] t_drv;
    logic [127:0] n_drv;
    logic [63:0]  np_drv;

    logic         obs_in_ready;
    logic         obs_out_valid;
    logic [255:0] obs_res;
    logic [255:0] obs_raw;

    int total = 0;
    int bad   = 0;

    mont_redc_ws_if #(.P_WIDTH(64),  .W_WIDTH(32)) if0 ();
    mont_redc_ws_if #(.P_WIDTH(128), .W_WIDTH(32)) if1 ();
    mont_redc_ws_if #(.P_WIDTH(64),  .W_WIDTH(64)) if2 ();

    mont_redc_ws #(.P_WIDTH(64),  .W_WIDTH(32)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    mont_redc_ws #(.P_WIDTH(128), .W_WIDTH(32)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    mont_redc_ws #(.P_WIDTH(64),  .W_WIDTH(64)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    assign if0.in_valid  = in_valid  && (sel == 2'd0);
    assign if0.out_ready = out_ready && (sel == 2'd0);
    assign if0.Mul_in    = t_drv[127:0];
    assign if0.N_in      = n_drv[63:0];
    assign if0.Nprime_in = np_drv[31:0];

    assign if1.in_valid  = in_valid  && (sel == 2'd1);
    assign if1.out_ready = out_ready && (sel == 2'd1);
    assign if1.Mul_in    = t_drv;
    assign if1.N_in      = n_drv;
    assign if1.Nprime_in = np_drv[31:0];

    assign if2.in_valid  = in_valid  && (sel == 2'd2);
    assign if2.out_ready = out_ready && (sel == 2'd2);
    assign if2.Mul_in    = t_drv[127:0];
    assign if2.N_in      = n_drv[63:0];
    assign if2.Nprime_in = np_drv;

    always_comb begin
        case (sel)
            2'd1: begin
                obs_in_ready  = if1.in_ready;
                obs_out_valid = if1.out_valid;
                obs_res       = 256'(if1.res_out);
                obs_raw       = 256'(if1.res_raw_out);
            end
            2'd2: begin
                obs_in_ready  = if2.in_ready;
                obs_out_valid = if2.out_valid;
                obs_res       = 256'(if2.res_out);
                obs_raw       = 256'(if2.res_raw_out);
            end
            default: begin
                obs_in_ready  = if0.in_ready;
                obs_out_valid = if0.out_valid;
                obs_res       = 256'(if0.res_out);
                obs_raw       = 256'(if0.res_raw_out);
            end
        endcase
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int cur_p();
        return (sel == 2'd1) ? 128 : 64;
    endfunction

    function automatic int cur_w();
        return (sel == 2'd2) ? 64 : 32;
    endfunction

    function automatic int cur_lat();
        return cur_p() / cur_w() + 1;
    endfunction

    // T * 2^-p mod N by halving modulo N p times.
    function automatic logic [255:0] mont_ref(input logic [255:0] t, input logic [255:0] n, input int p);
        logic [256:0] x;
        x = {1'b0, t % n};
        for (int i = 0; i < p; i++) x = x[0] ? (x + {1'b0, n}) >> 1 : x >> 1;
        return x[255:0];
    endfunction

    // -N^-1 mod 2^w via Newton iteration on the inverse.
    function automatic logic [63:0] nprime_of(input logic [63:0] n, input int w);
        logic [63:0] inv;
        inv = n;
        for (int i = 0; i < 6; i++) inv = inv * (64'd2 - n * inv);
        inv = 64'd0 - inv;
        return (w == 64) ? inv : {32'd0, inv[31:0]};
    endfunction

    function automatic logic [255:0] rand_bits(input int nbits);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        if (nbits < 256) r = r & ((256'd1 << nbits) - 256'd1);
        return r;
    endfunction

    task automatic start_op(input logic [255:0] t, input logic [255:0] n, input logic [63:0] np,
                            input bit release_out);
        int waited;
        waited = 0;
        @(negedge clk);
        t_drv    = t;
        n_drv    = n[127:0];
        np_drv   = np;
        in_valid = 1'b1;
        if (release_out) out_ready = 1'b1;
        while (!obs_in_ready && waited < 64) begin
            @(negedge clk);
            waited++;
        end
        check("accept_ready", 256'(obs_in_ready), 256'(1));
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("busy_in_ready", 256'(obs_in_ready), 256'(0));
    endtask

    task automatic wait_result(output logic [255:0] res, output logic [255:0] raw);
        int edges;
        edges = 0;
        while (!obs_out_valid && edges < 32) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check("latency", 256'(edges), 256'(cur_lat()));
        res = obs_res;
        raw = obs_raw;
    endtask

    task automatic take();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("drop_after_take", 256'(obs_out_valid), 256'(0));
        check("idle_ready", 256'(obs_in_ready), 256'(1));
    endtask

    task automatic dir_op(input string tag, input logic [255:0] t, input logic [255:0] n,
                          input logic [255:0] exp);
        logic [255:0] res, raw;
        start_op(t, n, nprime_of(n[63:0], cur_w()), 1'b0);
        wait_result(res, raw);
        check(tag, res, exp);
        take();
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [255:0] n, t, t2, res, raw, r0, expv;
        bit           stable, stale;

        rst_n     = 1'b0;
        sel       = 2'd0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        t_drv     = '0;
        n_drv     = '0;
        np_drv    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_out_valid", 256'(obs_out_valid), 256'(0));
        check("rst_res", obs_res, 256'(0));
        check("rst_raw", obs_raw, 256'(0));
        check("rst_in_ready", 256'(obs_in_ready), 256'(1));

        n = 256'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFC5;
        dir_op("unity_one", 256'd1 << 64, n, 256'd1);
        dir_op("unity_five", 256'd5 << 64, n, 256'd5);
        start_op(256'd0, n, nprime_of(n[63:0], 32), 1'b0);
        wait_result(res, raw);
        check("zero_res", res, 256'd0);
        check("zero_raw", raw, 256'd0);
        take();

        t = ((n - 256'd1) << 64) | ((256'd1 << 64) - 256'd1);
        start_op(t, n, nprime_of(n[63:0], 32), 1'b0);
        wait_result(res, raw);
        expv = mont_ref(t, n, 64);
        check("sub_raw_ge_n", 256'(raw >= n), 256'(1));
        check("sub_res", res, expv);
        check("sub_res_lt_n", 256'(res < n), 256'(1));
        take();

        // Abort an operation in RED with a two-cycle reset.
        start_op(256'd7 << 64, n, nprime_of(n[63:0], 32), 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("abort_out_valid", 256'(obs_out_valid), 256'(0));
        check("abort_res", obs_res, 256'(0));
        check("abort_in_ready", 256'(obs_in_ready), 256'(1));
        stale = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (obs_out_valid) stale = 1'b1;
        end
        check("abort_no_stale", 256'(stale), 256'(0));

        // Back-pressure, then back-to-back acceptance in DONE.
        t  = 256'd123456789 << 40;
        t2 = (256'd42 << 64) | 256'd99;
        start_op(t, n, nprime_of(n[63:0], 32), 1'b0);
        wait_result(r0, raw);
        check("bp_first_res", r0, mont_ref(t, n, 64));
        stable = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (obs_res !== r0 || !obs_out_valid || obs_in_ready) stable = 1'b0;
        end
        check("bp_stable", 256'(stable), 256'(1));
        start_op(t2, n, nprime_of(n[63:0], 32), 1'b1);
        check("bp_drop", 256'(obs_out_valid), 256'(0));
        wait_result(res, raw);
        check("bp_second_res", res, mont_ref(t2, n, 64));
        take();

        for (int s = 0; s < 3; s++) begin
            sel = 2'(s);
            for (int k = 0; k < NRND; k++) begin
                n    = rand_bits(cur_p()) | 256'd1;
                t    = rand_bits(2 * cur_p()) % (n << cur_p());
                expv = mont_ref(t, n, cur_p());
                start_op(t, n, nprime_of(n[63:0], cur_w()), 1'b0);
                wait_result(res, raw);
                check("rnd_res", res, expv);
                check("rnd_raw_mod", raw % n, expv);
                check("rnd_raw_lt_2n", 256'(raw < (n << 1)), 256'(1));
                take();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
